// File: rtl/bp_stream_byte_packer.sv
// Packs an 8-bit byte stream into little-endian words on a valid/ready stream.
// A partial word left idle for timeout_cycles_p cycles is discarded so the host can resync.
module bp_stream_byte_packer #(
    parameter int stream_data_width_p = 32,
    parameter int timeout_cycles_p    = 1024,
    parameter int count_width_p       = 32
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           byte_v_i,
    input  logic [7:0]                     byte_i,
    output logic                           byte_ready_o,
    output logic                           stream_v_o,
    output logic [stream_data_width_p-1:0] stream_data_o,
    input  logic                           stream_ready_i,
    output logic                           drop_o,
    output logic [count_width_p-1:0]       word_count_o,
    output logic [count_width_p-1:0]       drop_count_o
);

    localparam int n_bytes_lp   = stream_data_width_p / 8;
    localparam int idx_width_lp = $clog2(n_bytes_lp);
    localparam int asm_width_lp = stream_data_width_p - 8;
    localparam logic [idx_width_lp-1:0] last_idx_lp = idx_width_lp'(n_bytes_lp - 1);

    logic [idx_width_lp-1:0]        idx_r;
    logic [asm_width_lp-1:0]        asm_r;
    logic [stream_data_width_p-1:0] data_r;
    logic                           v_r;
    logic                           drop_r;
    logic [count_width_p-1:0]       word_count_r;
    logic [count_width_p-1:0]       drop_count_r;

    logic at_last;
    logic accept;
    logic xfer;
    logic timeout_fire;

    // The last byte may only enter when the output register is free or draining this cycle.
    assign at_last      = (idx_r == last_idx_lp);
    assign byte_ready_o = ~at_last | ~v_r | stream_ready_i;
    assign accept       = byte_v_i & byte_ready_o;
    assign xfer         = v_r & stream_ready_i;

    if (timeout_cycles_p > 0) begin : g_timeout
        localparam int tw_lp = $clog2(timeout_cycles_p + 1);
        logic [tw_lp-1:0] idle_r;

        // Fires on the cycle the idle count would reach its limit; an accepted byte wins.
        assign timeout_fire = (idx_r != '0) && !accept
                              && (idle_r == tw_lp'(timeout_cycles_p - 1));

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                idle_r <= '0;
            end else if (accept || (idx_r == '0) || timeout_fire) begin
                idle_r <= '0;
            end else begin
                idle_r <= idle_r + 1'b1;
            end
        end
    end else begin : g_no_timeout
        assign timeout_fire = 1'b0;
    end

    // NOTE: assembly bytes are only meaningful below idx, so this register needs no reset.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < n_bytes_lp - 1; k++) begin
            if (accept && (idx_r == idx_width_lp'(k))) begin
                asm_r[8*k +: 8] <= byte_i;
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            idx_r        <= '0;
            data_r       <= '0;
            v_r          <= 1'b0;
            drop_r       <= 1'b0;
            word_count_r <= '0;
            drop_count_r <= '0;
        end else begin
            drop_r <= timeout_fire;

            if (accept) begin
                idx_r <= at_last ? '0 : idx_r + 1'b1;
            end else if (timeout_fire) begin
                idx_r <= '0;
            end

            if (accept && at_last) begin
                v_r    <= 1'b1;
                data_r <= {byte_i, asm_r};
            end else if (xfer) begin
                v_r <= 1'b0;
            end

            if (xfer) begin
                word_count_r <= word_count_r + 1'b1;
            end

            if (timeout_fire && !(&drop_count_r)) begin
                drop_count_r <= drop_count_r + 1'b1;
            end
        end
    end

    assign stream_v_o    = v_r;
    assign stream_data_o = data_r;
    assign drop_o        = drop_r;
    assign word_count_o  = word_count_r;
    assign drop_count_o  = drop_count_r;

endmodule

// File: tb/tb_bp_stream_byte_packer.sv
// Bench for bp_stream_byte_packer: byte-queue reference model feeding a word scoreboard,
// plus a second instance with the timeout disabled.
module tb_bp_stream_byte_packer;

    localparam int W = 32;
    localparam int N = W / 8;
    localparam int T = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // Instance under the main model (timeout 8).
    logic         byte_v = 1'b0;
    logic [7:0]   byte_d = 8'h00;
    logic         byte_ready;
    logic         stream_v;
    logic [W-1:0] stream_data;
    logic         stream_ready = 1'b0;
    logic         drop;
    logic [31:0]  word_count;
    logic [31:0]  drop_count;

    // Instance with the timeout disabled.
    logic         v0 = 1'b0;
    logic [7:0]   b0 = 8'h00;
    logic         byte_ready0;
    logic         stream_v0;
    logic [W-1:0] stream_data0;
    logic         r0 = 1'b1;
    logic         drop0;
    logic [31:0]  word_count0;
    logic [31:0]  drop_count0;

    bp_stream_byte_packer #(
        .stream_data_width_p(W), .timeout_cycles_p(T), .count_width_p(32)
    ) dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .byte_v_i(byte_v), .byte_i(byte_d), .byte_ready_o(byte_ready),
        .stream_v_o(stream_v), .stream_data_o(stream_data), .stream_ready_i(stream_ready),
        .drop_o(drop), .word_count_o(word_count), .drop_count_o(drop_count)
    );

    bp_stream_byte_packer #(
        .stream_data_width_p(W), .timeout_cycles_p(0), .count_width_p(32)
    ) dut0 (
        .clk_i(clk), .reset_n_i(rst_n),
        .byte_v_i(v0), .byte_i(b0), .byte_ready_o(byte_ready0),
        .stream_v_o(stream_v0), .stream_data_o(stream_data0), .stream_ready_i(r0),
        .drop_o(drop0), .word_count_o(word_count0), .drop_count_o(drop_count0)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: bytes waiting to form a word, idle count since the last byte.
    logic [7:0]   pend[$];
    logic [W-1:0] sb[$];
    bit           m_out_v = 1'b0;
    bit           m_drop  = 1'b0;
    logic [31:0]  m_words = '0;
    logic [31:0]  m_drops = '0;
    int           idle    = 0;
    bit           last_acc = 1'b0;

    task automatic model_reset();
        pend.delete();
        sb.delete();
        m_out_v = 1'b0;
        m_drop  = 1'b0;
        m_words = '0;
        m_drops = '0;
        idle    = 0;
    endtask

    // One clock cycle: drive at negedge, compare against the model, then advance the model.
    task automatic step(input bit v, input logic [7:0] b, input bit rdy);
        bit           m_ready;
        bit           acc;
        logic [W-1:0] w;
        @(negedge clk);
        byte_v = v;
        byte_d = b;
        stream_ready = rdy;
        #1;
        m_ready = (pend.size() != N - 1) || !m_out_v || rdy;
        check("byte_ready", byte_ready, m_ready);
        check("stream_v", stream_v, m_out_v);
        check("drop", drop, m_drop);
        check("word_count", word_count, m_words);
        check("drop_count", drop_count, m_drops);
        acc = v && m_ready;
        last_acc = acc;
        m_drop = 1'b0;
        if (m_out_v && rdy) begin
            m_out_v = 1'b0;
            m_words = m_words + 1;
        end
        if (acc) begin
            pend.push_back(b);
            idle = 0;
            if (pend.size() == N) begin
                w = '0;
                for (int i = 0; i < N; i++) w = w | (W'(pend[i]) << (8 * i));
                sb.push_back(w);
                m_out_v = 1'b1;
                pend.delete();
            end
        end else if (pend.size() != 0) begin
            idle++;
            if (idle == T) begin
                pend.delete();
                idle = 0;
                m_drop = 1'b1;
                if (m_drops != '1) m_drops = m_drops + 1;
            end
        end else begin
            idle = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rdy);
        for (int t = 0; t < 20; t++) begin
            step(1'b1, b, rdy);
            if (last_acc) return;
        end
        errors++;
        checks++;
        $display("FAIL send_byte: byte %0h never accepted", b);
    endtask

    task automatic idle_cycles(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, rdy);
    endtask

    // Monitor: pops the expected word on every observed output transfer.
    initial begin
        logic [W-1:0] exp_w;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && stream_v && stream_ready) begin
                if (sb.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL word: got=%0h with no word expected", stream_data);
                end else begin
                    exp_w = sb.pop_front();
                    check("word", stream_data, exp_w);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_drop0;
        int pv;

        // Reset values while reset is held.
        #1 rst_n = 1'b0;
        #2;
        check("rst_stream_v", stream_v, 1'b0);
        check("rst_data", stream_data, '0);
        check("rst_drop", drop, 1'b0);
        check("rst_word_count", word_count, '0);
        check("rst_drop_count", drop_count, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Timeout disabled: 3 bytes, long pause, 1 byte.
        saw_drop0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            v0 = 1'b1;
            b0 = 8'(8'hA1 + i);
            #1 check("t0_byte_ready", byte_ready0, 1'b1);
        end
        @(negedge clk);
        v0 = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            saw_drop0 |= drop0;
        end
        v0 = 1'b1;
        b0 = 8'hA4;
        @(negedge clk);
        v0 = 1'b0;
        #1;
        check("t0_no_drop", saw_drop0, 1'b0);
        check("t0_drop_count", drop_count0, '0);
        check("t0_stream_v", stream_v0, 1'b1);
        check("t0_word", stream_data0, 32'hA4A3A2A1);
        @(negedge clk);
        #1 check("t0_word_count", word_count0, 32'd1);

        // Single word at full rate.
        send_byte(8'h78, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b1);
        idle_cycles(3, 1'b1);

        // Back-pressure: first word held, last byte of the second stalls, then release.
        for (int i = 0; i < 7; i++) step(1'b1, 8'(i), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'd7, 1'b0);
        send_byte(8'd7, 1'b1);
        for (int i = 8; i < 16; i++) send_byte(8'(i), 1'b1);
        idle_cycles(3, 1'b1);

        // Idle timeout discards a partial word, then a clean word follows.
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        idle_cycles(12, 1'b1);
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
        idle_cycles(3, 1'b1);

        // Byte arriving on the exact cycle the timeout would fire.
        send_byte(8'hC0, 1'b1);
        send_byte(8'hC1, 1'b1);
        idle_cycles(T - 1, 1'b1);
        send_byte(8'hC2, 1'b1);
        send_byte(8'hC3, 1'b1);
        idle_cycles(3, 1'b1);

        // Asynchronous reset with a word held and two bytes pending.
        for (int i = 0; i < 4; i++) send_byte(8'(8'h11 + i), 1'b0);
        send_byte(8'h21, 1'b0);
        send_byte(8'h22, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_stream_v", stream_v, 1'b0);
        check("arst_data", stream_data, '0);
        check("arst_drop", drop, 1'b0);
        check("arst_word_count", word_count, '0);
        check("arst_drop_count", drop_count, '0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) send_byte(8'(8'h31 + i), 1'b1);
        idle_cycles(3, 1'b1);

        // Randomized traffic with bursty, sparse and idle phases.
        for (int seg = 0; seg < 60; seg++) begin
            case ($urandom_range(2))
                0:       pv = 95;
                1:       pv = 60;
                default: pv = 3;
            endcase
            for (int i = 0; i < 50; i++) begin
                step($urandom_range(99) < pv, 8'($urandom), $urandom_range(99) < 60);
            end
        end

        idle_cycles(6, 1'b1);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bp_stream_byte_packer.md
Name: bp_stream_byte_packer

Overview:
- Upstream stage of the NBF stream loader.
- Packs the 8-bit byte stream from the host link (UART/JTAG RX) into stream_data_width_p-bit little-endian words.
- Presents those words on a valid/ready stream that connects directly to the loader's stream_v_i/stream_data_i/stream_ready_o.
- An idle timeout discards a stranded partial word, so the host can resynchronise by pausing.

Parameters:
- stream_data_width_p, 32: output word width. Must be a multiple of 8 and at least 16. N = stream_data_width_p/8 bytes per word.
- timeout_cycles_p, 1024: idle cycles with a partial word pending before that word is discarded. 0 disables the timeout.
- count_width_p, 32: width of the word and drop counters.

Ports:
- clk_i  input  1  clock.
- reset_n_i  input  1  asynchronous, active-low reset.
- byte_v_i  input  1  input byte valid.
- byte_i  input  8  input byte.
- byte_ready_o  output  1  byte accepted when byte_v_i & byte_ready_o.
- stream_v_o  output  1  output word valid.
- stream_data_o  output  stream_data_width_p  output word.
- stream_ready_i  input  1  consumer ready; a transfer occurs when stream_v_o & stream_ready_i.
- drop_o  output  1  one-cycle pulse when a partial word is discarded.
- word_count_o  output  count_width_p  words transferred out.
- drop_count_o  output  count_width_p  partial words discarded.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low (reset_n_i).
- Reset values, applied immediately on assertion:
  - stream_v_o=0, stream_data_o=0, drop_o=0.
  - word_count_o=0, drop_count_o=0.
  - Byte index and idle counter =0.
  - byte_ready_o=1 from the first cycle after deassertion.
  - Reset mid-operation discards both the partial word and any held output word, with no drop_o pulse.
- State: assembly register (N-1 bytes), byte index idx (0..N-1), output register plus its valid bit, idle counter.
- Packing:
  - An accepted byte at idx k is written to bits [8k+7:8k].
  - Byte 0 lands in bits [7:0].
  - idx increments on every accepted byte.
- Last byte (idx = N-1):
  - The full word (assembly bytes plus byte_i) loads the output register and idx returns to 0.
  - stream_v_o rises the next cycle (latency 1 cycle from last-byte acceptance).
- byte_ready_o:
  - Equals 1 when idx != N-1.
  - When idx == N-1 it equals (~stream_v_o | stream_ready_i). This is a combinational path from stream_ready_i, allowing full throughput of 1 byte/cycle.
- Output register:
  - stream_v_o/stream_data_o hold stable until the transfer occurs. A valid word is never dropped or changed while stalled.
  - Drain and refill in the same cycle is legal; the new word is valid the next cycle with no bubble.
- word_count_o increments by 1 per output transfer and wraps modulo 2^count_width_p.
- Idle timeout (only when timeout_cycles_p>0):
  - The idle counter increments on each cycle with idx!=0 and no byte accepted.
  - It clears on any accepted byte and whenever idx==0.
  - When the counter reaches timeout_cycles_p: idx←0, assembly discarded, drop_o=1 for that single next cycle, drop_count_o increments saturating at all-ones.
  - The output register is unaffected.
  - If a byte is accepted in the cycle the counter would reach its limit, the byte wins and no drop occurs.
  - idx==0 never times out.
- Back-pressure: while the output is stalled and idx==N-1, bytes stall and the idle counter runs. Timeout may therefore discard a stalled partial word. This is intended: the host must not stall mid-word longer than timeout_cycles_p.

Test Plan:
- Bytes 0x78,0x56,0x34,0x12 on consecutive cycles, stream_ready_i=1 → one word 0x12345678 with stream_v_o high exactly one cycle after byte 4; word_count_o=1; byte_ready_o never low.
- 16 back-to-back bytes with stream_ready_i held 0 after the first word → first word held stable; byte_ready_o=0 at idx 3; ready released → words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C in order, none lost, word_count_o=4.
- 2 bytes (0xAA,0xBB), then idle with timeout_cycles_p=8 → drop_o pulses once, 8 idle cycles after the last byte; drop_count_o=1; next 4 bytes 0x01..0x04 yield 0x04030201.
- Byte arrives on the exact cycle the timeout would fire → no drop_o, idx advances, word completes correctly.
- reset_n_i asserted asynchronously with a word held on stream_v_o and 2 bytes pending → all outputs and counters 0 immediately, no drop_o; after release, 4 bytes produce a clean word.
- timeout_cycles_p=0: 3 bytes then 5000 idle cycles, then 1 byte → no drop; word formed from all 4 bytes.
